// File: rtl/alu_result_stage.sv
// ALU result stage: buffers ALU results in a small FIFO toward writeback and
// holds the {Z,N,V} flag register. Optional sticky overflow: ALU_STICKY_OVF_EN.
module alu_result_stage #(
  parameter int DEPTH = 2,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [31:0]   in_y,
  input  logic          in_z,
  input  logic          in_v,
  input  logic          in_n,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_y,
  output logic [RW-1:0] out_rd,
`ifdef ALU_STICKY_OVF_EN
  input  logic          ovf_clr,
  output logic          ovf_sticky,
`endif
  output logic [2:0]    flags_q
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [31:0]   mem_y  [DEPTH];
  logic [RW-1:0] mem_rd [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          push, pop, flag_op;

  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Boolean and shift ops (01000, 01001, 01011) and the upper op space leave flags alone.
  always_comb begin
    flag_op = 1'b0;
    if (!in_op[4] && !(in_op inside {5'b01000, 5'b01001, 5'b01011}))
      flag_op = 1'b1;
  end

  always_comb begin
    out_y  = '0;
    out_rd = '0;
    if (out_valid) begin
      out_y  = mem_y[rd_ptr];
      out_rd = mem_rd[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]  <= in_y;
      mem_rd[wr_ptr] <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags follow acceptance order, not drain order, so branches see program order.
  always_ff @(posedge clk) begin
    if (reset)
      flags_q <= 3'b000;
    else if (push && flag_op)
      flags_q <= {in_z, in_n, in_v};
  end

`ifdef ALU_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (reset)
      ovf_sticky <= 1'b0;
    else if (push && flag_op && in_v)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios plus random traffic
// checked against a queue-based reference model. Build with ALU_STICKY_OVF_EN to cover the sticky flag.
module tb_alu_result_stage;

  localparam int DEPTH = 2;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [31:0]   in_y;
  logic          in_z, in_v, in_n;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_y;
  logic [RW-1:0] out_rd;
  logic [2:0]    flags_q;
`ifdef ALU_STICKY_OVF_EN
  logic          ovf_clr;
  logic          ovf_sticky;
  bit            model_sticky;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Reference model: accepted-but-not-drained results in order, and the flag register.
  logic [31+RW:0] sb[$];
  logic [2:0]     model_flags;

  alu_result_stage #(.DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y),
    .in_z(in_z), .in_v(in_v), .in_n(in_n), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_rd(out_rd),
`ifdef ALU_STICKY_OVF_EN
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky),
`endif
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  function automatic bit is_flag_op(input logic [4:0] op);
    int code;
    code = int'(op);
    return (code < 16) && (code != 8) && (code != 9) && (code != 11);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated from what the DUT accepted at this edge.
  task automatic applyStimulus(input bit v, input logic [4:0] op, input logic [31:0] y,
                               input bit z, input bit ov, input bit n, input logic [RW-1:0] rd,
                               input bit ordy, input bit clr, input bit rst, output bit accepted);
    @(posedge clk);
    #1;
    reset = rst; in_valid = v; in_op = op; in_y = y;
    in_z = z; in_v = ov; in_n = n; in_rd = rd; out_ready = ordy;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = clr;
`endif
    @(negedge clk);
    #1;
    accepted = 0;
    if (rst) begin
      sb.delete();
      model_flags = 3'b000;
`ifdef ALU_STICKY_OVF_EN
      model_sticky = 0;
`endif
    end else begin
      if (v && in_ready) begin
        accepted = 1;
        sb.push_back({rd, y});
        if (is_flag_op(op)) model_flags = {z, n, ov};
      end
`ifdef ALU_STICKY_OVF_EN
      if (accepted && is_flag_op(op) && ov) model_sticky = 1;
      else if (clr) model_sticky = 0;
`else
      if (clr) accepted = accepted;
`endif
    end
  endtask

  // Monitor: compares the DUT against the model and retires entries on handshakes.
  initial begin
    logic [31+RW:0] head;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        checkOutput("flags_q", 32'(flags_q), 32'(model_flags));
`ifdef ALU_STICKY_OVF_EN
        checkOutput("ovf_sticky", 32'(ovf_sticky), 32'(model_sticky));
`endif
        if (sb.size() != 0) begin
          head = sb[0];
          checkOutput("out_y", out_y, head[31:0]);
          checkOutput("out_rd", 32'(out_rd), 32'(head[31+RW:32]));
          if (out_ready) void'(sb.pop_front());
        end else begin
          checkOutput("out_y_idle", out_y, 32'h0);
          checkOutput("out_rd_idle", 32'(out_rd), 32'h0);
        end
      end
    end
  end

  initial begin
    bit acc;
    bit hv;
    logic [4:0] hop;
    logic [31:0] hy;
    bit hz, hov, hn;
    logic [RW-1:0] hrd;
    int guard;

    reset = 1; in_valid = 0; in_op = '0; in_y = '0; in_z = 0; in_v = 0; in_n = 0;
    in_rd = '0; out_ready = 0; model_flags = 3'b000;
`ifdef ALU_STICKY_OVF_EN
    ovf_clr = 0; model_sticky = 0;
`endif
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 0, 0, 1, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 0, 0, 1, acc);
    mon_en = 1;
    repeat (2) applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 0, 0, 0, acc);

    // Single result, immediate drain.
    applyStimulus(1, 5'b00000, 32'h0000_0005, 0, 0, 0, 5'd3, 1, 0, 0, acc);
    checkOutput("first_push_accepted", 32'(acc), 32'd1);
    repeat (2) applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);

    // Fill with writeback stalled, third result held, then drain in order.
    applyStimulus(1, 5'b01000, 32'h1111_1111, 0, 0, 0, 5'd1, 0, 0, 0, acc);
    applyStimulus(1, 5'b01001, 32'h2222_2222, 0, 0, 0, 5'd2, 0, 0, 0, acc);
    applyStimulus(1, 5'b01011, 32'h3333_3333, 0, 0, 0, 5'd4, 0, 0, 0, acc);
    checkOutput("third_held", 32'(acc), 32'd0);
    applyStimulus(1, 5'b01011, 32'h3333_3333, 0, 0, 0, 5'd4, 1, 0, 0, acc);
    repeat (3) applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);

    // Flag update by an add, then a boolean op leaves flags untouched.
    applyStimulus(1, 5'b00000, 32'h8000_0000, 0, 1, 1, 5'd7, 1, 0, 0, acc);
    applyStimulus(1, 5'b01000, 32'h0000_0000, 1, 0, 0, 5'd8, 1, 0, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);
    checkOutput("flags_after_bool", 32'(flags_q), 32'(3'b011));

    // Steady push+pop at count=1 across pointer wrap.
    applyStimulus(1, 5'b10001, 32'hA000_0000, 0, 0, 0, 5'd10, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 5'b10001, 32'hA000_0001 + 32'(i), 0, 0, 0, 5'(11 + i), 1, 0, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);

    // Reset with two entries queued discards them.
    applyStimulus(1, 5'b00001, 32'hDEAD_0001, 1, 0, 1, 5'd20, 0, 0, 0, acc);
    applyStimulus(1, 5'b00001, 32'hDEAD_0002, 0, 1, 0, 5'd21, 0, 0, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 0, 0, 1, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);

    // Sticky overflow survives later pushes until explicitly cleared.
    applyStimulus(1, 5'b00010, 32'h7FFF_FFFF, 0, 1, 0, 5'd5, 1, 0, 0, acc);
    applyStimulus(1, 5'b00010, 32'h0000_0001, 0, 0, 0, 5'd6, 1, 0, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 1, 0, acc);
    applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);

    // Random traffic; a refused result is held unchanged until accepted.
    hv = 0; hop = '0; hy = '0; hz = 0; hov = 0; hn = 0; hrd = '0;
    for (int i = 0; i < 400; i++) begin
      bit rst;
      rst = ($urandom_range(0, 99) == 0);
      if (!hv) begin
        hv  = ($urandom_range(0, 9) < 7);
        hop = 5'($urandom);
        hy  = $urandom;
        hz  = 1'($urandom);
        hov = 1'($urandom);
        hn  = 1'($urandom);
        hrd = RW'($urandom);
      end
      applyStimulus(hv, hop, hy, hz, hov, hn, hrd, ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 9) == 0), rst, acc);
      if (acc || rst) hv = 0;
    end

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      applyStimulus(0, 5'd0, 32'd0, 0, 0, 0, '0, 1, 0, 0, acc);
      guard++;
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
